channel_select: RTL and testbench
=================================

CHANNEL_SELECT -- requirements
Module: channel_select

Interface
REQ-001 SHALL have parameter NCH, default 8, meaning channels per interleaved frame.
REQ-002 SHALL have parameter LOGNCH, default 3, meaning channel-index width, with NCH <= 2^LOGNCH.
REQ-003 SHALL have parameter WDTH, default 32, meaning complex sample width (I and Q each WDTH/2).
REQ-004 SHALL have parameter MWDTH, default 1, meaning width of the metadata carried alongside each sample.
REQ-005 SHALL have parameter LOG_DEPTH, default 4, meaning the output FIFO holds 2^LOG_DEPTH entries.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port in_data, input, WDTH bits, the interleaved channelizer sample.
REQ-009 SHALL have port in_nd, input, 1 bit, strobe marking in_data, in_m and in_first valid this cycle.
REQ-010 SHALL have port in_m, input, MWDTH bits, metadata belonging to in_data.
REQ-011 SHALL have port in_first, input, 1 bit, high on the first kept channel sample of each frame.
REQ-012 SHALL have port sel_channel, input, LOGNCH bits, the channel index to extract.
REQ-013 SHALL have port out_data, output, WDTH bits, sample at the FIFO head.
REQ-014 SHALL have port out_m, output, MWDTH bits, metadata at the FIFO head.
REQ-015 SHALL have port out_valid, output, 1 bit, high whenever the FIFO is non-empty.
REQ-016 SHALL have port out_ready, input, 1 bit; the head entry is consumed when out_valid and out_ready are both high.
REQ-017 SHALL have port fifo_count, output, LOG_DEPTH+1 bits, the current FIFO occupancy.
REQ-018 SHALL have port locked, output, 1 bit, high while the block is in the LOCKED state.
REQ-019 SHALL have port error, output, 1 bit, the OR of sticky unaligned and sticky overflow.

Function
REQ-020 SHALL implement two states: SEARCH and LOCKED.
REQ-021 SHALL, in SEARCH, discard in_nd samples with in_first=0.
REQ-022 SHALL, in SEARCH on in_nd&in_first, treat the sample as index 0, go to LOCKED, and set idx to 1.
REQ-023 SHALL, in LOCKED, advance idx by one on each in_nd, wrapping from NCH-1 to 0.
REQ-024 SHALL, in LOCKED, resynchronise on in_nd&in_first with idx!=0: set sticky unaligned, treat the sample as index 0, and set idx to 1.
REQ-025 SHALL, in LOCKED, handle in_nd&!in_first with idx==0 as follows: set sticky unaligned, drop the sample, and go to SEARCH.
REQ-026 SHALL latch sel_channel into active_sel on every accepted index-0 sample; the index-0 comparison itself uses the live sel_channel value.
REQ-027 SHALL ignore sel_channel changes at all other times.
REQ-028 SHALL write {in_m, in_data} to the FIFO when the accepted sample index equals the selected channel.
REQ-029 SHALL write nothing when the selected index is >= NCH.
REQ-030 SHALL assert out_valid on the cycle after the write edge (latency 1); the FIFO is first-word fall-through.
REQ-031 SHALL, on a write when full with no read, drop the sample, set sticky overflow, and leave the contents unchanged.
REQ-032 SHALL, on a write when full with a simultaneous read, accept the write and leave fifo_count unchanged.
REQ-033 SHALL, on a simultaneous read and write when empty, ignore the read and accept the write.
REQ-034 SHALL wrap FIFO pointers modulo 2^LOG_DEPTH.
REQ-035 SHALL clear sticky errors only on rst.

Reset
REQ-036 SHALL, on rst, set state SEARCH, idx 0, active_sel 0, FIFO empty, fifo_count 0, out_valid 0, locked 0, error 0, out_data 0 and out_m 0.
REQ-037 SHALL give rst priority over in_nd and out_ready in the same cycle.
REQ-038 SHALL, on rst asserted mid-frame, discard buffered samples; after release it waits for a fresh in_first.

Structure
REQ-039 SHALL place the SEARCH/LOCKED state encodings in the shared package.
REQ-040 SHALL place the sticky error bit positions in the shared package.
REQ-041 SHALL implement the FIFO as one sub-module, channel_fifo, parameterised by width (WDTH+MWDTH) and LOG_DEPTH.

Verification
REQ-042 SHALL cover: NCH=8, sel=3, four aligned frames with data=frame*16+ch -> out_data 0x03, 0x13, 0x23, 0x33 in order, error=0.
REQ-043 SHALL cover: three samples with in_first=0 before the first frame -> locked=0 until in_first, then the frame is extracted normally.
REQ-044 SHALL cover: in_first arriving at idx=5 -> error=1, that sample becomes channel 0, and subsequent channel extraction stays correct.
REQ-045 SHALL cover: out_ready=0 with 17 frames, LOG_DEPTH=4 -> fifo_count=16, error=1, and out_data is the first 16 samples.
REQ-046 SHALL cover: sel changed from 3 to 6 mid-frame -> the current frame yields channel 3, and the next frame yields channel 6.
REQ-047 SHALL cover: rst with fifo_count=5 -> out_valid=0 and count=0 on the next cycle, with locked=0.

Source files
------------

// File: rtl/channel_select_pkg.sv
// channel_select_pkg: shared state encoding and sticky error bit positions.
package channel_select_pkg;
  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_e;
  localparam int ERR_UNALIGNED = 0;
  localparam int ERR_OVERFLOW  = 1;
  localparam int ERR_W         = 2;
endpackage

// File: rtl/channel_fifo.sv
// channel_fifo: first-word fall-through FIFO; full writes succeed only alongside a read.
module channel_fifo #(
  parameter int W         = 33,
  parameter int LOG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_i,
  input  logic [W-1:0]         wdata_i,
  input  logic                 rd_i,
  output logic [W-1:0]         rdata_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [LOG_DEPTH:0]   count_o
);
  logic [W-1:0]           mem_q [2**LOG_DEPTH];
  logic [LOG_DEPTH-1:0]   wp_q, rp_q;
  logic [LOG_DEPTH:0]     cnt_q;
  logic                   do_rd, do_wr;
  always_comb begin
    empty_o = cnt_q == '0;
    full_o  = cnt_q == (LOG_DEPTH+1)'(2**LOG_DEPTH);
    do_rd   = rd_i && !empty_o;
    do_wr   = wr_i && (!full_o || do_rd);
    rdata_o = empty_o ? '0 : mem_q[rp_q];
    count_o = cnt_q;
  end
  always_ff @(posedge clk)
    if (do_wr) mem_q[wp_q] <= wdata_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= do_wr ? wp_q + 1'b1 : wp_q;
      rp_q  <= do_rd ? rp_q + 1'b1 : rp_q;
      cnt_q <= cnt_q + (LOG_DEPTH+1)'(do_wr) - (LOG_DEPTH+1)'(do_rd);
    end
  end
endmodule

// File: rtl/channel_select.sv
// channel_select: locks onto interleaved frames and buffers the selected channel.
module channel_select
  import channel_select_pkg::*;
#(
  parameter int NCH       = 8,
  parameter int LOGNCH    = 3,
  parameter int WDTH      = 32,
  parameter int MWDTH     = 1,
  parameter int LOG_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WDTH-1:0]    in_data,
  input  logic               in_nd,
  input  logic [MWDTH-1:0]   in_m,
  input  logic               in_first,
  input  logic [LOGNCH-1:0]  sel_channel,
  output logic [WDTH-1:0]    out_data,
  output logic [MWDTH-1:0]   out_m,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LOG_DEPTH:0] fifo_count,
  output logic               locked,
  output logic               error
);
  state_e              state_q, state_d;
  logic [LOGNCH-1:0]   idx_q, idx_d, sel_q, sel_d, cur_sel, cur_idx;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                first_ok, mid_ok, drop, wr, rd, full, empty;
  always_comb begin
    first_ok = in_nd && in_first;
    mid_ok   = in_nd && !in_first && state_q == LOCKED && idx_q != '0;
    drop     = in_nd && !in_first && state_q == LOCKED && idx_q == '0;
    cur_sel  = first_ok ? sel_channel : sel_q;
    cur_idx  = first_ok ? '0 : idx_q;
    wr       = (first_ok || mid_ok) && cur_sel == cur_idx && int'(cur_sel) < NCH;
    rd       = out_ready && !empty;
    state_d  = first_ok ? LOCKED : drop ? SEARCH : state_q;
    idx_d    = first_ok ? LOGNCH'(1 % NCH) :
               mid_ok   ? (idx_q == LOGNCH'(NCH-1) ? '0 : idx_q + 1'b1) :
               drop     ? '0 : idx_q;
    sel_d    = first_ok ? sel_channel : sel_q;
    err_d    = err_q;
    err_d[ERR_UNALIGNED] = err_q[ERR_UNALIGNED] || drop ||
                           (first_ok && state_q == LOCKED && idx_q != '0);
    err_d[ERR_OVERFLOW]  = err_q[ERR_OVERFLOW] || (wr && full && !rd);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      idx_q   <= '0;
      sel_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end
  channel_fifo #(.W(WDTH+MWDTH), .LOG_DEPTH(LOG_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (wr),
    .wdata_i ({in_m, in_data}),
    .rd_i    (rd),
    .rdata_o ({out_m, out_data}),
    .empty_o (empty),
    .full_o  (full),
    .count_o (fifo_count)
  );
  assign out_valid = !empty;
  assign locked    = state_q == LOCKED;
  assign error     = |err_q;
endmodule

// File: tb/tb_channel_select.sv
// tb_channel_select: directed scenarios plus random traffic against a frame-level model.
module tb_channel_select;
  localparam int NCH = 8, LOGNCH = 3, WDTH = 32, MWDTH = 1, LD = 4, DEPTH = 16;
  logic              clk = 0, rst, in_nd, in_first, out_ready, out_valid, locked, error;
  logic [WDTH-1:0]   in_data, out_data;
  logic [MWDTH-1:0]  in_m, out_m;
  logic [LOGNCH-1:0] sel_channel;
  logic [LD:0]       fifo_count;
  always #5 clk = ~clk;
  channel_select #(.NCH(NCH), .LOGNCH(LOGNCH), .WDTH(WDTH), .MWDTH(MWDTH), .LOG_DEPTH(LD)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_nd(in_nd), .in_m(in_m), .in_first(in_first),
    .sel_channel(sel_channel), .out_data(out_data), .out_m(out_m), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .locked(locked), .error(error));
  int n_chk = 0, n_fail = 0;
  int pos = -1, asel = 0;
  bit unal = 0, ovf = 0;
  logic [WDTH+MWDTH-1:0] q[$];
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // pos is the frame position expected for the next sample; -1 means not locked
  task automatic model();
    bit acc = 0, rd, full;
    int idx = 0;
    if (rst) begin
      pos = -1; asel = 0; unal = 0; ovf = 0; q.delete();
      return;
    end
    rd = out_ready && q.size() > 0;
    full = q.size() == DEPTH;
    if (in_nd) begin
      if (in_first) begin
        if (pos > 0) unal = 1;
        acc = 1; idx = 0; asel = int'(sel_channel); pos = 1 % NCH;
      end else if (pos == 0) begin
        unal = 1; pos = -1;
      end else if (pos > 0) begin
        acc = 1; idx = pos; pos = (pos + 1) % NCH;
      end
    end
    if (rd) void'(q.pop_front());
    if (acc && idx == asel && asel < NCH) begin
      if (full && !rd) ovf = 1;
      else q.push_back({in_m, in_data});
    end
  endtask
  task automatic step(bit nd, bit first, logic [WDTH-1:0] d, logic [MWDTH-1:0] m);
    in_nd = nd; in_first = first; in_data = d; in_m = m;
    model();
    @(posedge clk); #1;
    check("valid", out_valid, q.size() != 0);
    check("count", fifo_count, q.size());
    check("locked", locked, pos >= 0);
    check("error", error, unal | ovf);
    if (q.size() != 0) begin
      check("data", out_data, q[0][WDTH-1:0]);
      check("meta", out_m, q[0][WDTH+:MWDTH]);
    end
  endtask
  task automatic do_reset();
    rst = 1; step(0, 0, 0, 0); rst = 0;
  endtask
  task automatic frame(int f);
    for (int c = 0; c < NCH; c++) step(1, c == 0, f * 16 + c, MWDTH'(f % 2));
  endtask
  task automatic drain_seq(int n, string tag);
    out_ready = 1;
    for (int i = 0; i < n; i++) begin
      check(tag, out_data, i * 16 + 3);
      step(0, 0, 0, 0);
    end
  endtask
  initial begin
    int fpos;
    rst = 1; in_nd = 0; in_first = 0; in_data = 0; in_m = 0; out_ready = 0; sel_channel = 3;
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    check("rst_data", out_data, 0);
    check("rst_meta", out_m, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) step(1, 0, $urandom, 0);
    check("search_locked", locked, 0);
    for (int f = 0; f < 4; f++) frame(f);
    check("aligned_count", fifo_count, 4);
    drain_seq(4, "aligned_seq");
    check("aligned_err", error, 0);
    for (int c = 0; c < 5; c++) step(1, c == 0, 100 + c, 0);
    step(1, 1, 200, 1);
    check("unal_err", error, 1);
    out_ready = 0;
    for (int c = 1; c < NCH; c++) step(1, 0, 200 + c, 0);
    check("unal_data", out_data, 203);
    do_reset();
    sel_channel = 3;
    for (int c = 0; c < 3; c++) step(1, c == 0, c, 0);
    sel_channel = 6;
    for (int c = 3; c < NCH; c++) step(1, 0, c, 0);
    frame(1);
    check("sel_count", fifo_count, 2);
    check("sel_first", out_data, 32'h03);
    out_ready = 1; step(0, 0, 0, 0);
    check("sel_second", out_data, 32'h16);
    do_reset();
    out_ready = 0; sel_channel = 3;
    for (int f = 0; f < 17; f++) frame(f);
    check("ovf_count", fifo_count, 16);
    check("ovf_err", error, 1);
    drain_seq(16, "ovf_seq");
    do_reset();
    out_ready = 0;
    for (int f = 0; f < 5; f++) frame(f);
    check("pre_rst_count", fifo_count, 5);
    rst = 1; out_ready = 1; step(1, 1, 32'h55, 1); rst = 0;
    check("rst_valid", out_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_locked", locked, 0);
    for (int c = 1; c < NCH; c++) step(1, 0, c, 0);
    fpos = 0;
    for (int i = 0; i < 3000; i++) begin
      bit nd, first;
      if ($urandom_range(0, 40) == 0) sel_channel = LOGNCH'($urandom);
      out_ready = ((i / 400) % 2 == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      nd = $urandom_range(0, 2) != 0;
      first = (fpos == 0) ^ ($urandom_range(0, 30) == 0);
      rst = $urandom_range(0, 400) == 0;
      step(nd, first, $urandom, MWDTH'($urandom));
      if (nd) fpos = first ? 1 : (fpos + 1) % NCH;
      rst = 0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
